ov5640_cam_top: RTL and testbench



---
 rtl/ov5640_pkg.sv | 21 ++
 rtl/ov5640_sccb_write.sv | 109 ++++++++++
 rtl/ov5640_cam_top.sv | 133 +++++++++++++
 tb/tb_ov5640_cam_top.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov5640_pkg.sv
// Shared constants for the OV5640 front end: SCCB device address, the power-up
// register table and the SCCB state encoding.
package ov5640_pkg;

    localparam logic [7:0] DEV_ADDR  = 8'h78;
    localparam int         TABLE_LEN = 11;

    // {addr16, data8}, sent in index order
    localparam logic [23:0] REG_TABLE [TABLE_LEN] = '{
        24'h3103_11, 24'h3008_82, 24'h3017_FF, 24'h3018_FF,
        24'h4300_61, 24'h501F_01,
        24'h3808_02, 24'h3809_80, 24'h380A_01, 24'h380B_E0,
        24'h3008_02
    };

    typedef enum logic [3:0] {
        ST_IDLE, ST_START, ST_BYTE0, ST_BYTE1, ST_BYTE2, ST_BYTE3,
        ST_STOP, ST_GAP, ST_DONE
    } sccb_state_t;

endpackage

// File: rtl/ov5640_sccb_write.sv
// Single SCCB write engine: START, device/addr-hi/addr-lo/data bytes (9 bits
// each, 9th bit released high), STOP. One bit = four quarter-periods of QUARTER cycles.
module ov5640_sccb_write
    import ov5640_pkg::*;
#(
    parameter int QUARTER = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic [15:0] addr16,
    input  logic [7:0]  data8,
    output logic        busy,
    output logic        done,
    output logic        scl,
    output logic        sda
);

    localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;

    sccb_state_t   state, state_nxt;
    logic [QW-1:0] qcnt;
    logic [1:0]    quarter;
    logic [3:0]    bit_idx;
    logic [15:0]   addr_q;
    logic [7:0]    data_q;
    logic [7:0]    cur_byte;
    logic          tick, period_end, scl_nxt, sda_nxt;

    assign tick       = (qcnt == QW'(QUARTER - 1));
    assign period_end = tick && (quarter == 2'd3);
    assign busy       = (state != ST_IDLE);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        scl_nxt   = 1'b1;
        sda_nxt   = 1'b1;
        cur_byte  = DEV_ADDR;
        case (state)
            ST_BYTE1: cur_byte = addr_q[15:8];
            ST_BYTE2: cur_byte = addr_q[7:0];
            ST_BYTE3: cur_byte = data_q;
            default:  cur_byte = DEV_ADDR;
        endcase
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_START;
            ST_START: begin
                sda_nxt = !quarter[1];
                if (period_end) state_nxt = ST_BYTE0;
            end
            ST_BYTE0, ST_BYTE1, ST_BYTE2, ST_BYTE3: begin
                // scl low for quarters 0-1; sda set up while scl is low
                scl_nxt = quarter[1];
                sda_nxt = (bit_idx == 4'd8) ? 1'b1 : cur_byte[3'd7 - bit_idx[2:0]];
                if (period_end && bit_idx == 4'd8) begin
                    case (state)
                        ST_BYTE0: state_nxt = ST_BYTE1;
                        ST_BYTE1: state_nxt = ST_BYTE2;
                        ST_BYTE2: state_nxt = ST_BYTE3;
                        default:  state_nxt = ST_STOP;
                    endcase
                end
            end
            ST_STOP: begin
                scl_nxt = quarter[1];
                sda_nxt = (quarter == 2'd3);
                if (period_end) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= ST_IDLE;
            qcnt    <= '0;
            quarter <= 2'd0;
            bit_idx <= 4'd0;
            addr_q  <= 16'h0;
            data_q  <= 8'h0;
            scl     <= 1'b1;
            sda     <= 1'b1;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            scl   <= scl_nxt;
            sda   <= sda_nxt;
            done  <= (state == ST_STOP) && period_end;
            if (state == ST_IDLE) begin
                qcnt    <= '0;
                quarter <= 2'd0;
                bit_idx <= 4'd0;
                if (start) begin
                    addr_q <= addr16;
                    data_q <= data8;
                end
            end else begin
                qcnt <= tick ? '0 : qcnt + 1'b1;
                if (tick) quarter <= quarter + 2'd1;
                if (period_end)
                    bit_idx <= (state inside {ST_BYTE0, ST_BYTE1, ST_BYTE2, ST_BYTE3}
                                && bit_idx != 4'd8) ? bit_idx + 4'd1 : 4'd0;
            end
        end
    end

endmodule

// File: rtl/ov5640_cam_top.sv
// OV5640 front end: power-up hold, SCCB register table load, then DVP byte
// pairing into RGB565 words once FRAME_SKIP frames have passed.
module ov5640_cam_top
    import ov5640_pkg::*;
#(
    parameter int CLK_FREQ    = 25_000_000,
    parameter int SCCB_FREQ   = 250_000,
    parameter int INIT_CYCLES = 500_000,
    parameter int FRAME_SKIP  = 10
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        ov5640_pclk,
    input  logic        ov5640_href,
    input  logic        ov5640_vsync,
    input  logic [7:0]  ov5640_data,
    output logic        sys_init_down,
    output logic        cfg_down,
    output logic        sccb_scl,
    output logic        sccb_sda,
    output logic        ov5640_wr_en,
    output logic [15:0] ov5640_data_out
);

    localparam int SCL_PERIOD = CLK_FREQ / SCCB_FREQ;
    localparam int IW         = $clog2(INIT_CYCLES);
    localparam int PW         = $clog2(SCL_PERIOD);
    localparam int FW         = $clog2(FRAME_SKIP + 1);

    // pixel bus is sampled on sys_clk; pclk is sys_clk-synchronous on this board
    logic unused_pclk;
    assign unused_pclk = ov5640_pclk;

    logic [IW-1:0] init_cnt;
    sccb_state_t   cfg_state, cfg_nxt;
    logic [3:0]    idx;
    logic [PW-1:0] gap_cnt;
    logic [23:0]   entry;
    logic          eng_start, eng_busy, eng_done;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            init_cnt      <= '0;
            sys_init_down <= 1'b0;
        end else if (!sys_init_down) begin
            if (init_cnt == IW'(INIT_CYCLES - 1)) sys_init_down <= 1'b1;
            else                                  init_cnt      <= init_cnt + 1'b1;
        end
    end

    assign entry = REG_TABLE[idx];

    always_comb begin
        cfg_nxt   = cfg_state;
        eng_start = 1'b0;
        case (cfg_state)
            ST_IDLE: if (sys_init_down && !eng_busy) begin
                eng_start = 1'b1;
                cfg_nxt   = ST_START;
            end
            ST_START: if (eng_done)
                cfg_nxt = (idx == 4'(TABLE_LEN - 1)) ? ST_DONE : ST_GAP;
            ST_GAP: if (gap_cnt == PW'(SCL_PERIOD - 1) && !eng_busy) begin
                eng_start = 1'b1;
                cfg_nxt   = ST_START;
            end
            ST_DONE: cfg_nxt = ST_DONE;
            default: cfg_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cfg_state <= ST_IDLE;
            idx       <= 4'd0;
            gap_cnt   <= '0;
            cfg_down  <= 1'b0;
        end else begin
            cfg_state <= cfg_nxt;
            if (cfg_state == ST_START && cfg_nxt == ST_GAP) idx <= idx + 4'd1;
            gap_cnt <= (cfg_state == ST_GAP) ? gap_cnt + 1'b1 : '0;
            if (cfg_nxt == ST_DONE) cfg_down <= 1'b1;
        end
    end

    ov5640_sccb_write #(.QUARTER(SCL_PERIOD / 4)) u_sccb (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .start   (eng_start),
        .addr16  (entry[23:8]),
        .data8   (entry[7:0]),
        .busy    (eng_busy),
        .done    (eng_done),
        .scl     (sccb_scl),
        .sda     (sccb_sda)
    );

    logic          vsync_d, cap_en, phase, pair_flag;
    logic [FW-1:0] frame_cnt;
    logic [7:0]    byte_hi, byte_lo;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            vsync_d         <= 1'b0;
            frame_cnt       <= '0;
            cap_en          <= 1'b0;
            phase           <= 1'b0;
            pair_flag       <= 1'b0;
            byte_hi         <= 8'h0;
            byte_lo         <= 8'h0;
            ov5640_wr_en    <= 1'b0;
            ov5640_data_out <= 16'h0;
        end else begin
            vsync_d <= ov5640_vsync;
            if (cfg_down && !cap_en && ov5640_vsync && !vsync_d) begin
                if (frame_cnt == FW'(FRAME_SKIP - 1)) cap_en <= 1'b1;
                frame_cnt <= frame_cnt + 1'b1;
            end
            // phase clears whenever href drops, so a trailing odd byte is discarded
            if (ov5640_href) begin
                phase <= !phase;
                if (!phase) byte_hi <= ov5640_data;
                else        byte_lo <= ov5640_data;
            end else begin
                phase <= 1'b0;
            end
            pair_flag    <= ov5640_href && phase;
            ov5640_wr_en <= pair_flag && cap_en;
            if (pair_flag && cap_en) ov5640_data_out <= {byte_hi, byte_lo};
        end
    end

endmodule

// File: tb/tb_ov5640_cam_top.sv
// Bench for ov5640_cam_top: power-up timing, SCCB frame decode, reset during
// configuration, frame skip and RGB565 byte pairing on scaled-down frames.
module tb_ov5640_cam_top;

    localparam int CLK_FREQ    = 25_000_000;
    localparam int SCCB_FREQ   = CLK_FREQ / 8;
    localparam int INIT_CYCLES = 100;
    localparam int FRAME_SKIP  = 2;
    localparam int LINE_LEN    = 784;
    localparam int NVEC        = 16;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        href    = 1'b0;
    logic        vsync   = 1'b0;
    logic [7:0]  data    = 8'h00;
    logic        sys_init_down, cfg_down, sccb_scl, sccb_sda, ov5640_wr_en;
    logic [15:0] ov5640_data_out;

    always #5 sys_clk = ~sys_clk;

    ov5640_cam_top #(
        .CLK_FREQ(CLK_FREQ), .SCCB_FREQ(SCCB_FREQ),
        .INIT_CYCLES(INIT_CYCLES), .FRAME_SKIP(FRAME_SKIP)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .ov5640_pclk     (sys_clk),
        .ov5640_href     (href),
        .ov5640_vsync    (vsync),
        .ov5640_data     (data),
        .sys_init_down   (sys_init_down),
        .cfg_down        (cfg_down),
        .sccb_scl        (sccb_scl),
        .sccb_sda        (sccb_sda),
        .ov5640_wr_en    (ov5640_wr_en),
        .ov5640_data_out (ov5640_data_out)
    );

    typedef struct {
        int         nbytes;
        logic [7:0] start_val;
        bit         vs;
        bit         cap;
        int         exp_strobes;
        logic [15:0] exp_last;
    } line_vec_t;

    typedef struct {
        logic [15:0] word;
        int          cyc;
    } exp_t;

    logic [23:0] exp_tab [11] = '{
        24'h310311, 24'h300882, 24'h3017FF, 24'h3018FF, 24'h430061, 24'h501F01,
        24'h380802, 24'h380980, 24'h380A01, 24'h380BE0, 24'h300802
    };

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          strobes = 0;
    logic [15:0] last_word = 16'h0;
    exp_t        exp_q [$];
    exp_t        e;
    line_vec_t   vecs [NVEC];

    logic        prev_scl = 1'b1, prev_sda = 1'b1;
    bit          in_frame = 1'b0;
    int          nb = 0;
    int          dec_frames = 0;
    logic        bits [40];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_init_down"}, sys_init_down, 0);
        check({tag, "_cfg_down"},  cfg_down, 0);
        check({tag, "_scl"},       sccb_scl, 1);
        check({tag, "_sda"},       sccb_sda, 1);
        check({tag, "_wr_en"},     ov5640_wr_en, 0);
        check({tag, "_data_out"},  ov5640_data_out, 0);
    endtask

    // call right after releasing reset on a negedge
    task automatic wait_init(input string tag);
        int n;
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge sys_clk);
            #1;
            n = i;
            if (sys_init_down) break;
        end
        check({tag, "_init_delay"}, n, INIT_CYCLES);
    endtask

    task automatic decode_frame();
        logic [7:0]  got, want;
        logic [23:0] ent;
        check("sccb_bitcount", nb, 37);
        if (dec_frames >= 11) begin
            check("sccb_extra_frame", dec_frames, 10);
        end else begin
            ent = exp_tab[dec_frames];
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < 8; j++) got[7-j] = bits[9*k+j];
                case (k)
                    0:       want = 8'h78;
                    1:       want = ent[23:16];
                    2:       want = ent[15:8];
                    default: want = ent[7:0];
                endcase
                check($sformatf("sccb_w%0d_byte%0d", dec_frames, k), got, want);
                check($sformatf("sccb_w%0d_ack%0d", dec_frames, k), bits[9*k+8], 1);
            end
        end
    endtask

    initial forever begin
        @(posedge sys_clk);
        cyc++;
    end

    // SCCB line decoder
    initial forever begin
        @(negedge sys_clk);
        if (sys_rst) begin
            in_frame   = 1'b0;
            nb         = 0;
            dec_frames = 0;
        end else if (prev_scl && sccb_scl && prev_sda && !sccb_sda) begin
            in_frame = 1'b1;
            nb       = 0;
        end else if (prev_scl && sccb_scl && !prev_sda && sccb_sda) begin
            if (in_frame) begin
                decode_frame();
                dec_frames++;
            end
            in_frame = 1'b0;
        end else if (in_frame && sccb_scl && !prev_scl) begin
            if (nb < 40) bits[nb] = sccb_sda;
            nb++;
        end
        prev_scl = sccb_scl;
        prev_sda = sccb_sda;
    end

    // pixel output monitor
    initial forever begin
        @(negedge sys_clk);
        if (sys_rst) begin
            last_word = 16'h0;
        end else begin
            if (ov5640_wr_en) begin
                strobes++;
                if (exp_q.size() == 0) begin
                    check("wr_en_unexpected", ov5640_wr_en, 0);
                    last_word = ov5640_data_out;
                end else begin
                    e = exp_q.pop_front();
                    check("pix_word", ov5640_data_out, e.word);
                    check("pix_latency", cyc, e.cyc);
                    last_word = e.word;
                end
            end else begin
                check("data_hold", ov5640_data_out, last_word);
            end
            if (cfg_down) begin
                check("sccb_idle_scl", sccb_scl, 1);
                check("sccb_idle_sda", sccb_sda, 1);
            end
        end
    end

    task automatic drive_line(input line_vec_t v, input int n);
        int         s0;
        logic [7:0] b, hi;
        s0 = strobes;
        hi = 8'h00;
        for (int i = 0; i < LINE_LEN; i++) begin
            @(negedge sys_clk);
            vsync = v.vs;
            if (i < v.nbytes) begin
                b    = v.start_val + 8'(i);
                href = 1'b1;
                data = b;
                if (i % 2 == 0) hi = b;
                else if (v.cap) exp_q.push_back('{word: {hi, b}, cyc: cyc + 2});
            end else begin
                href = 1'b0;
                data = 8'h00;
            end
        end
        check($sformatf("line%0d_strobes", n), strobes - s0, v.exp_strobes);
        check($sformatf("line%0d_last_word", n), ov5640_data_out, v.exp_last);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        for (int f = 0; f < 2; f++) begin
            vecs[4*f+0] = '{640, 8'h00, 1'b0, 1'b0, 0, 16'h0000};
            vecs[4*f+1] = '{640, 8'h00, 1'b0, 1'b0, 0, 16'h0000};
            vecs[4*f+2] = '{0,   8'h00, 1'b0, 1'b0, 0, 16'h0000};
            vecs[4*f+3] = '{0,   8'h00, 1'b1, 1'b0, 0, 16'h0000};
        end
        vecs[8]  = '{640, 8'h00, 1'b0, 1'b1, 320, 16'h7E7F};
        vecs[9]  = '{640, 8'h80, 1'b0, 1'b1, 320, 16'hFEFF};
        vecs[10] = '{3,   8'h10, 1'b0, 1'b1, 1,   16'h1011};
        vecs[11] = '{4,   8'h20, 1'b0, 1'b1, 2,   16'h2223};
        vecs[12] = '{2,   8'hFE, 1'b0, 1'b1, 1,   16'hFEFF};
        vecs[13] = '{5,   8'h40, 1'b0, 1'b1, 2,   16'h4243};
        vecs[14] = '{0,   8'h00, 1'b0, 1'b1, 0,   16'h4243};
        vecs[15] = '{0,   8'h00, 1'b1, 1'b1, 0,   16'h4243};

        sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check_reset("por");
        @(negedge sys_clk);
        sys_rst = 1'b0;
        wait_init("por");

        // reset in the middle of the third write
        for (int i = 0; i < 5000 && !(dec_frames == 2 && in_frame && nb >= 10); i++)
            @(negedge sys_clk);
        check("midcfg_reached", 32'(dec_frames == 2 && in_frame), 1);
        @(posedge sys_clk);
        #3;
        sys_rst = 1'b1;
        #1;
        check_reset("midcfg");
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        wait_init("rerun");

        // a vsync edge before cfg_down must not count toward the frame skip
        repeat (50) @(negedge sys_clk);
        vsync = 1'b1;
        repeat (5) @(negedge sys_clk);
        vsync = 1'b0;

        for (int i = 0; i < 20000 && !cfg_down; i++) @(negedge sys_clk);
        check("cfg_down_rise", cfg_down, 1);
        check("sccb_write_count", dec_frames, 11);

        for (int n = 0; n < NVEC; n++) drive_line(vecs[n], n);

        repeat (4) @(negedge sys_clk);
        check("pending_words", exp_q.size(), 0);
        check("cfg_down_sticky", cfg_down, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
